// File: rtl/elm_seq_pkg.sv
// Shared definitions for the ELM hidden-layer MAC sequencer: state encoding and width helper.
package elm_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_ISSUE  = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_OUTPUT = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Address/index width that stays at least one bit even for a single entry.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elm_mac_sequencer_if.sv
// Datapath-side bus of the MAC sequencer: memory read addresses, accumulator strobes, result handshake.
interface elm_mac_sequencer_if #(
  parameter int N_IN  = 8,
  parameter int N_HID = 16
);
  localparam int XA_W = elm_seq_pkg::clog2_min1(N_IN);
  localparam int WA_W = elm_seq_pkg::clog2_min1(N_IN * N_HID);
  localparam int HA_W = elm_seq_pkg::clog2_min1(N_HID);

  logic            rd_en;
  logic [XA_W-1:0] x_addr;
  logic [WA_W-1:0] w_addr;
  logic            acc_clr;
  logic            acc_load;
  logic            out_valid;
  logic            out_ready;
  logic [HA_W-1:0] out_idx;

  modport master (
    output rd_en, x_addr, w_addr, acc_clr, acc_load, out_valid, out_idx,
    input  out_ready
  );

  modport slave (
    input  rd_en, x_addr, w_addr, acc_clr, acc_load, out_valid, out_idx,
    output out_ready
  );

endinterface

// File: rtl/elm_valid_delay.sv
// Fixed-latency 1-bit valid pipe aligning the read strobe with the multiplier output.
module elm_valid_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic din_i,
  output logic dout_o
);

  logic [LAT-1:0] sh_q, sh_d;

  always_comb begin
    sh_d    = '0;
    sh_d[0] = din_i;
    for (int k = 1; k < LAT; k++) begin
      sh_d[k] = sh_q[k-1];
    end
  end

  // Flush drops every in-flight strobe so nothing lands after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else if (flush_i) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign dout_o = sh_q[LAT-1];

endmodule

// File: rtl/elm_mac_sequencer.sv
// Sequences one hidden-layer MAC pass: clear, issue N_IN reads, drain the multiplier, hand off each neuron.
module elm_mac_sequencer
  import elm_seq_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int N_HID   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  elm_mac_sequencer_if.master bus
);

  localparam int XA_W = clog2_min1(N_IN);
  localparam int WA_W = clog2_min1(N_IN * N_HID);
  localparam int HA_W = clog2_min1(N_HID);
  localparam int CW   = clog2_min1(MUL_LAT);

  state_t          state_q, state_d;
  logic [XA_W-1:0] i_q, i_d;
  logic [WA_W-1:0] w_q, w_d;
  logic [HA_W-1:0] j_q, j_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_en_s;
  logic            acc_load_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      w_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      w_q     <= w_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
    end
  end

  // w_q is a running weight address: it walks j*N_IN+i across neurons without a multiplier.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    w_d     = w_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          j_d     = '0;
          w_d     = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        i_d     = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_d = w_q + 1'b1;
        if (i_q == XA_W'(N_IN - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(MUL_LAT - 1)) begin
          state_d = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          if (j_q == HA_W'(N_HID - 1)) begin
            state_d = ST_DONE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Addresses and index are masked outside their phase so idle outputs read as zero.
  always_comb begin
    rd_en_s       = (state_q == ST_ISSUE);
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    bus.rd_en     = rd_en_s;
    bus.x_addr    = rd_en_s ? i_q : '0;
    bus.w_addr    = rd_en_s ? w_q : '0;
    bus.acc_clr   = (state_q == ST_CLEAR);
    bus.acc_load  = acc_load_s;
    bus.out_valid = (state_q == ST_OUTPUT);
    bus.out_idx   = (state_q == ST_OUTPUT) ? j_q : '0;
  end

  elm_valid_delay #(
    .LAT (MUL_LAT)
  ) u_load_dly (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .din_i   (rd_en_s),
    .dout_o  (acc_load_s)
  );

endmodule

// File: tb/tb_elm_mac_sequencer.sv
// Directed bench: a 4x2 (latency 2) sequencer and a 1x1 (latency 1) edge instance on one clock.
module tb_elm_mac_sequencer;

  logic clk;
  logic rst;
  logic start, abort, busy, done;
  logic start_e, abort_e, busy_e, done_e;
  int   checks;
  int   errors;

  elm_mac_sequencer_if #(.N_IN(4), .N_HID(2)) bus ();
  elm_mac_sequencer_if #(.N_IN(1), .N_HID(1)) bus_e ();

  elm_mac_sequencer #(.N_IN(4), .N_HID(2), .MUL_LAT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  elm_mac_sequencer #(.N_IN(1), .N_HID(1), .MUL_LAT(1)) dut_e (
    .clk   (clk),
    .rst   (rst),
    .start (start_e),
    .abort (abort_e),
    .busy  (busy_e),
    .done  (done_e),
    .bus   (bus_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected fields: busy, rd_en, x_addr, w_addr, acc_clr, acc_load, out_valid, out_idx, done.
  task automatic chk_m(input string tag, input int b, input int r, input int xa, input int wa,
                       input int c, input int l, input int v, input int oi, input int d);
    logic [11:0] exp_v, got;
    exp_v = {1'(b), 1'(r), 2'(xa), 3'(wa), 1'(c), 1'(l), 1'(v), 1'(oi), 1'(d)};
    got   = {busy, bus.rd_en, bus.x_addr, bus.w_addr, bus.acc_clr, bus.acc_load,
             bus.out_valid, bus.out_idx, done};
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp_v);
    end
  endtask

  task automatic chk_e(input string tag, input int b, input int r, input int xa, input int wa,
                       input int c, input int l, input int v, input int oi, input int d);
    logic [8:0] exp_v, got;
    exp_v = {1'(b), 1'(r), 1'(xa), 1'(wa), 1'(c), 1'(l), 1'(v), 1'(oi), 1'(d)};
    got   = {busy_e, bus_e.rd_en, bus_e.x_addr, bus_e.w_addr, bus_e.acc_clr, bus_e.acc_load,
             bus_e.out_valid, bus_e.out_idx, done_e};
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp_v);
    end
  endtask

  // Entered in the CLEAR cycle of neuron j; leaves during its last OUTPUT cycle with out_ready=1.
  task automatic run_neuron(input int j, input int stall, input bit pulse);
    out_ready_set(stall == 0);
    chk_m($sformatf("n%0d_clr", j), 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      start = pulse && (k == 1);
      chk_m($sformatf("n%0d_iss%0d", j, k), 1, 1, k, 4 * j + k, 0, (k >= 2) ? 1 : 0, 0, 0, 0);
    end
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_m($sformatf("n%0d_drn%0d", j, k), 1, 0, 0, 0, 0, 1, 0, 0, 0);
    end
    tick();
    chk_m($sformatf("n%0d_out", j), 1, 0, 0, 0, 0, 0, 1, j, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk_m($sformatf("n%0d_stall%0d", j, s), 1, 0, 0, 0, 0, 0, 1, j, 0);
    end
    out_ready_set(1'b1);
  endtask

  task automatic out_ready_set(input bit v);
    bus.out_ready = v;
  endtask

  task automatic run_pass(input int st0, input int st1, input bit pulse, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_neuron(0, st0, pulse);
    tick();
    run_neuron(1, st1, 1'b0);
    tick();
    chk_m({tag, "_done"}, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_m({tag, "_idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    start_e         = 1'b0;
    abort_e         = 1'b0;
    bus.out_ready   = 1'b1;
    bus_e.out_ready = 1'b1;
    #1;
    chk_m("rst_main", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_e("rst_edge", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    chk_m("idle_main", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Edge configuration: one read, one load, one result, one done.
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    chk_e("e_clr", 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    chk_e("e_iss", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_e("e_load", 1, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    chk_e("e_out", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chk_e("e_done", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_e("e_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    run_pass(0, 0, 1'b0, "basic");
    run_pass(5, 0, 1'b0, "bp");
    run_pass(0, 0, 1'b1, "pulse");

    // Abort while issuing i=2.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_m("ab_clr", 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    chk_m("ab_iss0", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_m("ab_iss1", 1, 1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk_m("ab_iss2", 1, 1, 2, 2, 0, 1, 0, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_m("ab_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_m($sformatf("ab_quiet%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    run_pass(0, 0, 1'b0, "post_ab");

    // Asynchronous reset in the middle of DRAIN.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_m("rs_drn", 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_m("rs_async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk_m("rs_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_pass(0, 0, 1'b0, "post_rs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elm_mac_sequencer.md
Name: elm_mac_sequencer

Overview:
Controller that sequences one hidden-layer MAC pass of the ELM datapath. For each hidden neuron j it clears the accumulator register, streams N_IN input/weight read addresses, and asserts the accumulator load strobe aligned to the multiplier pipeline latency. It then presents the finished neuron result to a downstream consumer via a valid/ready handshake. It sits between the top-level ELM control and the multiplier and accumulator-register datapath; acc_clr drives the accumulator's synchronous clear and acc_load drives its load.

Parameters:
N_IN, 8, inputs (features) per neuron; >=1
N_HID, 16, hidden neurons per pass; >=1
MUL_LAT, 2, cycles from rd_en to product valid at accumulator data_in; >=1
XA_W, $clog2(N_IN) (min 1), x_addr width
WA_W, $clog2(N_IN*N_HID) (min 1), w_addr width
HA_W, $clog2(N_HID) (min 1), neuron index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE
out_ready  in  1  downstream accepts the neuron result
busy  out  1  high in every state except IDLE
rd_en  out  1  input/weight memory read strobe
x_addr  out  XA_W  input feature address i
w_addr  out  WA_W  weight address j*N_IN+i
acc_clr  out  1  clear accumulator (one cycle per neuron)
acc_load  out  1  accumulate product into accumulator
out_valid  out  1  accumulator holds final sum for neuron out_idx
out_idx  out  HA_W  neuron index j of the presented result
done  out  1  one-cycle pulse when the pass completes

Behaviour:
- Reset (async): state=IDLE; i=0, j=0, delay line=0. All outputs 0.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs except none.
- IDLE: on start=1, j<=0 and go to CLEAR. start is ignored in every other state.
- CLEAR: acc_clr=1 for exactly one cycle; i<=0; go to ISSUE.
- ISSUE: rd_en=1, x_addr=i, w_addr=j*N_IN+i. The address is computed with a running base register, not a multiplier. If i==N_IN-1, go to DRAIN; otherwise i<=i+1. The phase lasts exactly N_IN cycles.
- Delay line: rd_en is delayed MUL_LAT cycles. acc_load equals the delayed rd_en, so acc_load rises exactly MUL_LAT cycles after the first rd_en and lasts N_IN cycles.
- DRAIN: wait MUL_LAT cycles until the delay line is empty, then go to OUTPUT.
- OUTPUT: out_valid=1, out_idx=j, held stable until out_ready=1.
  - On handshake with j==N_HID-1: go to DONE.
  - Otherwise: j<=j+1 and go to CLEAR.
- DONE: done=1 for one cycle; go to IDLE.
- Minimum cycles per neuron: 1+N_IN+MUL_LAT+1.
- abort=1 in any non-IDLE state: next state is IDLE. The delay line is flushed, so no acc_load occurs after the abort cycle. No done is issued. abort has priority over out_ready.
- rst asserted mid-operation: immediate return to reset values. The accumulator is not cleared by this block; its own reset handles that.
- N_IN=1: ISSUE lasts one cycle. N_HID=1: DONE follows the first handshake.

Decomposition:
- Package elm_seq_pkg:
  - state encoding IDLE/CLEAR/ISSUE/DRAIN/OUTPUT/DONE as a 3-bit localparam set
  - shared width helper for clog2-with-minimum-1
- Sub-module elm_valid_delay: MUL_LAT-deep 1-bit shift register with async reset and synchronous flush, used for the rd_en->acc_load alignment.

Test Plan:
- Basic pass, N_IN=4, N_HID=2, MUL_LAT=2, out_ready=1:
  - start -> acc_clr at cycle 1; rd_en cycles 2-5 with x_addr 0..3, w_addr 0..3; acc_load cycles 4-7; out_valid/out_idx=0 at cycle 8.
  - Neuron 1 then uses w_addr 4..7; out_idx=1; done one cycle after the second handshake; busy falls with done.
- Backpressure: out_ready held 0 for 5 cycles in OUTPUT -> out_valid and out_idx stay constant, no acc_clr or rd_en; progress resumes the cycle after out_ready=1.
- Abort in ISSUE at i=2 -> IDLE next cycle; acc_load never asserts after the abort cycle; done stays 0; a subsequent start restarts at j=0, i=0.
- start pulsed while busy -> ignored; address sequence and done timing identical to the basic pass.
- Async rst asserted mid-DRAIN, not clock-aligned -> all outputs 0 immediately; IDLE after release; next start behaves as the basic pass.
- Edge config N_IN=1, N_HID=1, MUL_LAT=1 -> one rd_en, then one acc_load the next cycle, then out_valid, then a single done pulse.
